instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 59 +++++
 rtl/instr_fetch.sv | 106 ++++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared defaults, FSM encoding and helpers for the instruction fetch unit.
package instr_fetch_pkg;

    localparam logic [31:0] DefaultResetPc   = 32'h0000_0000;
    localparam int unsigned DefaultFifoDepth = 2;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StDrop = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {instr, pc} entries with flush; simultaneous push/pop allowed when full.
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem_q[rptr_q];

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= push_data;
                wptr_q        <= wptr_q + AW'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: one outstanding memory read, redirect handling, buffered delivery to decode.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DefaultResetPc,
    parameter int unsigned FIFO_DEPTH = DefaultFifoDepth
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  req_addr_q, req_addr_d;
    logic         run_q;
    logic         req_fire, fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [63:0]  fifo_head;

    // run_q keeps the request low until the first edge after reset release.
    assign imem_req_valid = run_q && (state_q == StIdle) && !fifo_full;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign instr_valid    = !fifo_empty;
    assign instr          = fifo_head[63:32];
    assign instr_pc       = fifo_head[31:0];
    assign fifo_pop       = instr_valid && instr_ready;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        fifo_push  = 1'b0;

        if (req_fire) begin
            req_addr_d = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (redirect_valid) begin
            fetch_pc_d = align_pc(redirect_pc);
        end

        unique case (state_q)
            StIdle: begin
                if (req_fire) begin
                    state_d = redirect_valid ? StDrop : StWait;
                end
            end
            StWait: begin
                // A response arriving with a redirect retires the request but is discarded.
                if (imem_rsp_valid) begin
                    state_d   = StIdle;
                    fifo_push = !redirect_valid;
                end else if (redirect_valid) begin
                    state_d = StDrop;
                end
            end
            StDrop: begin
                if (imem_rsp_valid) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= '0;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            run_q      <= 1'b1;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (64)
    ) u_fetch_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (fifo_push),
        .push_data ({imem_rsp_data, req_addr_q}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule
